// File: rtl/phys_free_list_if.sv
`default_nettype none
// ============================================================================
// Module   : phys_free_list_if
// Brief    : Dispatch-pop / commit-push / flush bundle of the free list.
// Revision : 1.0 - initial release
// ============================================================================
interface phys_free_list_if #(
    parameter int PHYS_REG_WIDTH = 6,
    parameter int DEPTH          = 16,
    parameter int PTR_WIDTH      = $clog2(DEPTH)
);
    logic                      deq_req;
    logic                      deq_valid;
    logic [PHYS_REG_WIDTH-1:0] deq_preg;
    logic                      commit_valid;
    logic [PHYS_REG_WIDTH-1:0] commit_old_preg;
    logic                      flush;
    logic [PTR_WIDTH:0]        count;

    modport master (
        output deq_req,
        output commit_valid,
        output commit_old_preg,
        output flush,
        input  deq_valid,
        input  deq_preg,
        input  count
    );

    modport slave (
        input  deq_req,
        input  commit_valid,
        input  commit_old_preg,
        input  flush,
        output deq_valid,
        output deq_preg,
        output count
    );
endinterface
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// ============================================================================
// Module   : phys_free_list
// Brief    : Circular free list of physical registers with flush rollback.
// Revision : 1.0 - initial release
// ============================================================================
module phys_free_list #(
    parameter int PHYS_REG_WIDTH = 6,
    parameter int DEPTH          = 16,
    parameter int PTR_WIDTH      = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    phys_free_list_if.slave   fl
);

    localparam int                 c_FIRST_PREG = 32;
    localparam logic [PTR_WIDTH:0] c_PTR_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] c_PTR_DEPTH  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] c_TAIL_RST   = {1'b1, {PTR_WIDTH{1'b0}}};

    logic [PHYS_REG_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH:0] head_q,        head_d;
    logic [PTR_WIDTH:0] commit_head_q, commit_head_d;
    logic [PTR_WIDTH:0] tail_q,        tail_d;

    logic [PTR_WIDTH:0] w_count;
    logic               w_deq_fire;

    // Flush restores head to the commit pointer as it stands after this
    // cycle's commit, so a same-cycle commit is never re-handed out.
    always_comb begin
        w_count       = tail_q - head_q;
        w_deq_fire    = fl.deq_req && (w_count != '0) && !fl.flush;
        commit_head_d = commit_head_q;
        tail_d        = tail_q;
        if (fl.commit_valid) begin
            commit_head_d = commit_head_q + c_PTR_ONE;
            tail_d        = tail_q + c_PTR_ONE;
        end
        head_d = head_q;
        if (fl.flush) begin
            head_d = commit_head_d;
        end else if (w_deq_fire) begin
            head_d = head_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= c_TAIL_RST;
        end else begin
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PHYS_REG_WIDTH'(c_FIRST_PREG + i);
            end
        end else if (fl.commit_valid) begin
            mem_q[tail_q[PTR_WIDTH-1:0]] <= fl.commit_old_preg;
        end
    end

    assign fl.deq_valid = (w_count != '0);
    assign fl.deq_preg  = mem_q[head_q[PTR_WIDTH-1:0]];
    assign fl.count     = w_count;

`ifndef SYNTHESIS
    logic [PTR_WIDTH:0] w_commit_span;
    assign w_commit_span = tail_q - commit_head_q;

    always @(posedge clk) begin
        if (!rst && fl.commit_valid) begin
            assert (w_commit_span <= c_PTR_DEPTH);
            assert (fl.commit_old_preg != '0);
            assert (commit_head_q != head_q);
        end
    end
`endif

endmodule
`default_nettype wire
